// File: rtl/cell_board_tester.sv
// cell_board_tester: exhaustive truth-table exerciser for RV523 logic-cell boards.
// Optional soak mode: define CELL_TESTER_LOOP_EN to repeat passes while start is held.
module cell_board_tester #(
    parameter int SETTLE_CYCLES = 16,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       cell_sel,
    output logic [5:0]       stim,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [5:0]       fail_vec
);

    localparam int CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    state_t           state;
    logic [3:0]       sel_q;
    logic [5:0]       vec;
    logic [5:0]       last_vec;
    logic [CNT_W-1:0] cnt;
    logic             sync1;
    logic             sync2;
`ifdef CELL_TESTER_LOOP_EN
    logic             sel_ok;
`endif

    // Highest vector index, i.e. 2^n-1 for an n-input cell.
    function automatic logic [5:0] last_vec_of(input logic [3:0] sel);
        logic [5:0] r;
        case (sel)
            4'd0:                      r = 6'd1;
            4'd1, 4'd2:                r = 6'd3;
            4'd3, 4'd4, 4'd5, 4'd6:    r = 6'd7;
            4'd7, 4'd8:                r = 6'd15;
            4'd9, 4'd10:               r = 6'd31;
            4'd11, 4'd12:              r = 6'd63;
            default:                   r = 6'd0;
        endcase
        return r;
    endfunction

    function automatic logic cell_fn(input logic [3:0] sel,
                                     input logic [5:0] v);
        logic a, b, c, d, e, f, y;
        {f, e, d, c, b, a} = v;
        case (sel)
            4'd0:    y = ~a;
            4'd1:    y = ~(a & b);
            4'd2:    y = ~(a | b);
            4'd3:    y = ~(a & b & c);
            4'd4:    y = ~(a | b | c);
            4'd5:    y = ~((a & b) | c);
            4'd6:    y = ~((a | b) & c);
            4'd7:    y = ~((a & b) | (c & d));
            4'd8:    y = ~((a | b) & (c | d));
            4'd9:    y = ~((a & b) | (c & d) | e);
            4'd10:   y = ~((a | b) & (c | d) & e);
            4'd11:   y = ~((a & b) | (c & d) | (e & f));
            4'd12:   y = ~((a | b) & (c | d) & (e | f));
            default: y = 1'b0;
        endcase
        return y;
    endfunction

    logic             expected_y;
    logic             mismatch;
    logic [ERR_W-1:0] err_inc;
    logic [ERR_W-1:0] err_next;

    always_comb begin
        expected_y = cell_fn(sel_q, vec);
        mismatch   = (sync2 != expected_y);
        err_inc    = (&err_cnt) ? err_cnt : err_cnt + ERR_W'(1);
        err_next   = mismatch ? err_inc : err_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            vec      <= '0;
            last_vec <= '0;
            cnt      <= '0;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stim     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            fail_vec <= '0;
`ifdef CELL_TESTER_LOOP_EN
            sel_ok   <= 1'b0;
`endif
        end else begin
            sync1 <= dut_y;
            sync2 <= sync1;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sel_q    <= cell_sel;
                        last_vec <= last_vec_of(cell_sel);
                        vec      <= '0;
                        err_cnt  <= '0;
                        fail_vec <= '0;
                        pass     <= 1'b0;
`ifdef CELL_TESTER_LOOP_EN
                        sel_ok   <= (cell_sel <= 4'd12);
`endif
                        if (cell_sel <= 4'd12) begin
                            busy  <= 1'b1;
                            state <= APPLY;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                APPLY: begin
                    stim  <= vec;
                    cnt   <= CNT_LOAD;
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state <= SAMPLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_inc;
                        if (err_cnt == '0) begin
                            fail_vec <= vec;
                        end
                    end
                    if (vec == last_vec) begin
                        done  <= 1'b1;
                        pass  <= (err_next == '0);
                        stim  <= '0;
                        state <= FINISH;
`ifdef CELL_TESTER_LOOP_EN
                        busy  <= start;
`else
                        busy  <= 1'b0;
`endif
                    end else begin
                        vec   <= vec + 6'd1;
                        state <= APPLY;
                    end
                end
                FINISH: begin
`ifdef CELL_TESTER_LOOP_EN
                    // Soak: accumulated errors carry into the next pass.
                    if (start && sel_ok) begin
                        vec   <= '0;
                        busy  <= 1'b1;
                        state <= APPLY;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_board_tester.sv
// Bench for cell_board_tester: board models on three instances
// (settle 16, 3 and 6), scoreboard of expected end-of-test results.
module tb_cell_board_tester;

    localparam int M_GOOD   = 0;
    localparam int M_STUCK0 = 1;
    localparam int M_STUCK1 = 2;
    localparam int M_FLAKY  = 3;
    localparam int LIMIT    = 3000;

    typedef struct {
        int cycles;
        int err;
        int fvec;
        int pass;
    } exp_t;

    exp_t exp_q[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic [3:0] sel_a = 4'd0;
    logic [5:0] stim_a;
    logic       y_a;
    logic       busy_a, done_a, pass_a;
    logic [7:0] err_a;
    logic [5:0] fv_a;

    logic       start_bc = 1'b0;
    logic [3:0] sel_bc = 4'd12;
    logic [5:0] stim_b, stim_c;
    logic       y_b, y_c;
    logic       busy_b, done_b, pass_b;
    logic       busy_c, done_c, pass_c;
    logic [7:0] err_b, err_c;
    logic [5:0] fv_b, fv_c;
    logic [2:0] dl_b = '0;
    logic [2:0] dl_c = '0;

    int mode = M_GOOD;
    int done_cnt = 0;
    int pass_base = 0;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cell_board_tester #(.SETTLE_CYCLES(16), .ERR_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cell_sel(sel_a),
        .stim(stim_a), .dut_y(y_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_cnt(err_a), .fail_vec(fv_a)
    );

    cell_board_tester #(.SETTLE_CYCLES(3), .ERR_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_bc), .cell_sel(sel_bc),
        .stim(stim_b), .dut_y(y_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_cnt(err_b), .fail_vec(fv_b)
    );

    cell_board_tester #(.SETTLE_CYCLES(6), .ERR_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_bc), .cell_sel(sel_bc),
        .stim(stim_c), .dut_y(y_c), .busy(busy_c), .done(done_c),
        .pass(pass_c), .err_cnt(err_c), .fail_vec(fv_c)
    );

    // Cells as AOI/OAI group lists: {oai, g0, g1, g2}.
    function automatic logic [9:0] cell_def(input int sel);
        logic [9:0] d;
        case (sel)
            0:  d = {1'b0, 3'd1, 3'd0, 3'd0};
            1:  d = {1'b0, 3'd2, 3'd0, 3'd0};
            2:  d = {1'b1, 3'd2, 3'd0, 3'd0};
            3:  d = {1'b0, 3'd3, 3'd0, 3'd0};
            4:  d = {1'b1, 3'd3, 3'd0, 3'd0};
            5:  d = {1'b0, 3'd2, 3'd1, 3'd0};
            6:  d = {1'b1, 3'd2, 3'd1, 3'd0};
            7:  d = {1'b0, 3'd2, 3'd2, 3'd0};
            8:  d = {1'b1, 3'd2, 3'd2, 3'd0};
            9:  d = {1'b0, 3'd2, 3'd2, 3'd1};
            10: d = {1'b1, 3'd2, 3'd2, 3'd1};
            11: d = {1'b0, 3'd2, 3'd2, 3'd2};
            12: d = {1'b1, 3'd2, 3'd2, 3'd2};
            default: d = '0;
        endcase
        return d;
    endfunction

    function automatic int n_of(input int sel);
        logic [9:0] d;
        d = cell_def(sel);
        return int'(d[8:6]) + int'(d[5:3]) + int'(d[2:0]);
    endfunction

    function automatic logic ref_y(input int sel, input logic [5:0] v);
        logic [9:0] d;
        logic oai, acc, term;
        int idx, gsz;
        d = cell_def(sel);
        oai = d[9];
        acc = oai;
        idx = 0;
        for (int gi = 0; gi < 3; gi++) begin
            gsz = (gi == 0) ? int'(d[8:6]) : (gi == 1) ? int'(d[5:3]) : int'(d[2:0]);
            if (gsz != 0) begin
                term = ~oai;
                for (int k = 0; k < gsz; k++) begin
                    term = oai ? (term | v[idx]) : (term & v[idx]);
                    idx++;
                end
                acc = oai ? (acc & term) : (acc | term);
            end
        end
        return ~acc;
    endfunction

    function automatic exp_t model(input int sel, input int md);
        exp_t e;
        int n;
        logic y, good;
        e.cycles = 1;
        e.err = 0;
        e.fvec = 0;
        e.pass = 0;
        if (sel <= 12) begin
            n = n_of(sel);
            for (int v = 0; v < (1 << n); v++) begin
                good = ref_y(sel, 6'(v));
                y = (md == M_STUCK0) ? 1'b0 : (md == M_STUCK1) ? 1'b1 : good;
                if (y != good) begin
                    if (e.err == 0) e.fvec = v;
                    if (e.err < 255) e.err++;
                end
            end
            e.pass = (e.err == 0) ? 1 : 0;
            e.cycles = (1 << n) * 17 + 1;
        end
        return e;
    endfunction

    // Board under test for instance A.
    always_comb begin
        y_a = ref_y(int'(sel_a), stim_a);
        case (mode)
            M_STUCK0: y_a = 1'b0;
            M_STUCK1: y_a = 1'b1;
            M_FLAKY:
                if ((done_cnt - pass_base) == 1 && stim_a == 6'd1) y_a = ~y_a;
            default: ;
        endcase
    end

    // OAI222 boards with a 3-clock output delay.
    always @(posedge clk) begin
        dl_b <= {dl_b[1:0], ref_y(12, stim_b)};
        dl_c <= {dl_c[1:0], ref_y(12, stim_c)};
        if (done_a) done_cnt <= done_cnt + 1;
    end
    assign y_b = dl_b[2];
    assign y_c = dl_c[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_a(input int sel, input int md);
        exp_t e;
        int cyc;
        bit nz;
        exp_q.push_back(model(sel, md));
        mode = md;
        sel_a = 4'(sel);
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        chk("busy_after_start", {31'd0, busy_a}, (sel <= 12) ? 32'd1 : 32'd0);
        cyc = 1;
        nz = 1'b0;
        while (!done_a && cyc < LIMIT) begin
            if (stim_a != 6'd0) nz = 1'b1;
            @(posedge clk);
            #1 cyc++;
        end
        chk("done_seen", {31'd0, done_a}, 32'd1);
        e = exp_q.pop_front();
        chk("cycles", cyc, e.cycles);
        chk("err_cnt", {24'd0, err_a}, e.err);
        chk("fail_vec", {26'd0, fv_a}, e.fvec);
        chk("pass", {31'd0, pass_a}, e.pass);
        chk("busy_at_done", {31'd0, busy_a}, 32'd0);
        chk("stim_at_done", {26'd0, stim_a}, 32'd0);
        if (sel > 12) chk("illegal_stim", {31'd0, nz}, 32'd0);
        @(posedge clk);
        #1;
        chk("done_pulse", {31'd0, done_a}, 32'd0);
        chk("pass_hold", {31'd0, pass_a}, e.pass);
    endtask

    initial begin
        exp_t e;
        int cyc, cb, cc;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_stim", {26'd0, stim_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_pass", {31'd0, pass_a}, 32'd0);
        chk("rst_err", {24'd0, err_a}, 32'd0);
        chk("rst_fvec", {26'd0, fv_a}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_a(1, M_GOOD);
        run_a(9, M_STUCK0);
        run_a(1, M_STUCK1);
        run_a(14, M_GOOD);
        run_a(15, M_GOOD);
        run_a(0, M_GOOD);
        run_a(8, M_STUCK0);
        run_a(12, M_GOOD);
        run_a(5, M_STUCK1);

        // Reset during settle of vector 5 on NOR3.
        mode = M_STUCK1;
        sel_a = 4'd4;
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        cyc = 0;
        while (stim_a != 6'd5 && cyc < LIMIT) begin
            @(posedge clk);
            #1 cyc++;
        end
        chk("reach_vec5", {26'd0, stim_a}, 32'd5);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_stim", {26'd0, stim_a}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("mid_rst_done", {31'd0, done_a}, 32'd0);
        chk("mid_rst_err", {24'd0, err_a}, 32'd0);
        chk("mid_rst_fvec", {26'd0, fv_a}, 32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (150) begin
            @(posedge clk);
            #1 seen = seen | done_a;
        end
        chk("no_done_after_rst", {31'd0, seen}, 32'd0);
        run_a(4, M_GOOD);

        // Delayed OAI222 boards: settle 3 is too short, settle 6 suffices.
        exp_q.push_back('{cycles: 64 * 4 + 1, err: 1, fvec: 0, pass: 0});
        exp_q.push_back('{cycles: 64 * 7 + 1, err: 0, fvec: 0, pass: 1});
        start_bc = 1'b1;
        @(posedge clk);
        #1 start_bc = 1'b0;
        cyc = 1;
        cb = 0;
        cc = 0;
        while ((cb == 0 || cc == 0) && cyc < LIMIT) begin
            if (done_b && cb == 0) cb = cyc;
            if (done_c && cc == 0) cc = cyc;
            @(posedge clk);
            #1 cyc++;
        end
        e = exp_q.pop_front();
        chk("s3_cycles", cb, e.cycles);
        chk("s3_err_nz", {31'd0, (err_b != 8'd0)}, e.err);
        chk("s3_pass", {31'd0, pass_b}, e.pass);
        e = exp_q.pop_front();
        chk("s6_cycles", cc, e.cycles);
        chk("s6_err", {24'd0, err_c}, e.err);
        chk("s6_fvec", {26'd0, fv_c}, e.fvec);
        chk("s6_pass", {31'd0, pass_c}, e.pass);
        chk("s6_busy", {31'd0, busy_c}, 32'd0);

`ifdef CELL_TESTER_LOOP_EN
        // NOT board failing vector 1 only on the second soak pass.
        exp_q.push_back('{cycles: 35, err: 0, fvec: 0, pass: 1});
        exp_q.push_back('{cycles: 35, err: 1, fvec: 1, pass: 0});
        mode = M_FLAKY;
        pass_base = done_cnt;
        sel_a = 4'd0;
        start_a = 1'b1;
        @(posedge clk);
        #1 cyc = 1;
        while (!done_a && cyc < LIMIT) begin
            @(posedge clk);
            #1 cyc++;
        end
        e = exp_q.pop_front();
        chk("loop1_cycles", cyc, e.cycles);
        chk("loop1_err", {24'd0, err_a}, e.err);
        chk("loop1_pass", {31'd0, pass_a}, e.pass);
        chk("loop1_busy", {31'd0, busy_a}, 32'd1);
        cyc = 0;
        repeat (3) begin
            @(posedge clk);
            #1 cyc++;
        end
        start_a = 1'b0;
        while (!done_a && cyc < LIMIT) begin
            @(posedge clk);
            #1 cyc++;
        end
        e = exp_q.pop_front();
        chk("loop2_cycles", cyc, e.cycles);
        chk("loop2_err", {24'd0, err_a}, e.err);
        chk("loop2_fvec", {26'd0, fv_a}, e.fvec);
        chk("loop2_pass", {31'd0, pass_a}, e.pass);
        chk("loop2_busy", {31'd0, busy_a}, 32'd0);
        @(posedge clk);
        #1 chk("loop_end_done", {31'd0, done_a}, 32'd0);
        mode = M_GOOD;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
